// File: rtl/video_src_scheduler_pkg.sv
// Shared types and constants for the frame-synchronous video source scheduler.
package vsched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [23:0] BLACK_RGB = 24'h000000;
    localparam int unsigned DWELL_W   = 8;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    // Minimum index width for n sources (n in 2..256); never returns 0.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i <= 8; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/video_src_scheduler_if.sv
// Video timing, source request/pixel and arbitration status bundle for the scheduler.
interface video_src_scheduler_if
    import vsched_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDX_W = idx_width(N_SRC)
);
    logic                  hs_in;
    logic                  vs_in;
    logic                  de_in;
    logic [N_SRC-1:0]      src_req;
    logic [N_SRC*24-1:0]   src_rgb;
    logic                  force_en;
    logic [IDX_W-1:0]      force_idx;

    logic                  hs_o;
    logic                  vs_o;
    logic                  de_o;
    logic [23:0]           rgb_o;
    logic [N_SRC-1:0]      grant;
    logic                  grant_valid;
    logic                  switch_pulse;

    modport master (
        output hs_in, vs_in, de_in, src_req, src_rgb, force_en, force_idx,
        input  hs_o, vs_o, de_o, rgb_o, grant, grant_valid, switch_pulse
    );

    modport slave (
        input  hs_in, vs_in, de_in, src_req, src_rgb, force_en, force_idx,
        output hs_o, vs_o, de_o, rgb_o, grant, grant_valid, switch_pulse
    );
endinterface

// File: rtl/video_src_scheduler_rr_pick.sv
// Combinational round-robin search: first candidate after 'last', wrapping, 'last' itself considered last.
module vsched_rr_pick
    import vsched_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDX_W = idx_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic [N_SRC-1:0] excl_mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_SRC-1:0] cand;
    logic [IDX_W-1:0] pos [N_SRC];

    always_comb begin
        cand = req & ~excl_mask;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            pos[k] = IDX_W'((32'(last) + k + 1) % N_SRC);
        end
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!found && cand[pos[k]]) begin
                found = 1'b1;
                idx   = pos[k];
            end
        end
    end

endmodule

// File: rtl/video_src_scheduler.sv
// Frame-synchronous owner arbitration for a shared video path, with 1-clk registered output datapath.
module video_src_scheduler
    import vsched_pkg::*;
#(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned IDX_W      = idx_width(N_SRC),
    parameter int unsigned MIN_FRAMES = 4,
    parameter logic        VS_POL     = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    video_src_scheduler_if.slave bus
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 vs_prev_q, vs_prev_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;
    logic                 de_q, de_d;
    logic [23:0]          rgb_q, rgb_d;
    logic                 switch_q, switch_d;

    logic                 frame_start;
    logic                 force_ok;
    logic                 owner_req;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [N_SRC-1:0]     grant_oh;
    logic [23:0]          rgb_arr [N_SRC];
    logic                 take;
    logic [IDX_W-1:0]     new_owner;
    logic [DWELL_W-1:0]   dwell_inc;

    // The current owner is excluded so pick_found means "some other source wants the path".
    vsched_rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req       (bus.src_req),
        .last      (last_q),
        .excl_mask (grant_oh),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(N_SRC - 1);
            dwell_q   <= '0;
            vs_prev_q <= ~VS_POL;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            rgb_q     <= BLACK_RGB;
            switch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            dwell_q   <= dwell_d;
            vs_prev_q <= vs_prev_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            rgb_q     <= rgb_d;
            switch_q  <= switch_d;
        end
    end

    always_comb begin
        frame_start = (bus.vs_in == VS_POL) && (vs_prev_q != VS_POL);
        force_ok    = bus.force_en && (32'(bus.force_idx) < N_SRC);
        owner_req   = bus.src_req[owner_q];
        dwell_inc   = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;

        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        dwell_d   = dwell_q;
        switch_d  = 1'b0;
        take      = 1'b0;
        new_owner = owner_q;

        if (frame_start) begin
            unique case (state_q)
                IDLE: begin
                    if (force_ok) begin
                        take      = 1'b1;
                        new_owner = bus.force_idx;
                    end else if (pick_found) begin
                        take      = 1'b1;
                        new_owner = pick_idx;
                    end
                end
                HOLD: begin
                    if (force_ok && bus.force_idx != owner_q) begin
                        take      = 1'b1;
                        new_owner = bus.force_idx;
                    end else if (force_ok) begin
                        dwell_d = dwell_inc;
                    end else if (!owner_req) begin
                        if (pick_found) begin
                            take      = 1'b1;
                            new_owner = pick_idx;
                        end else begin
                            state_d = IDLE;
                            dwell_d = '0;
                        end
                    end else if (dwell_q >= DWELL_W'(MIN_FRAMES - 1) && pick_found) begin
                        take      = 1'b1;
                        new_owner = pick_idx;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end
            endcase
        end

        if (take) begin
            state_d  = HOLD;
            owner_d  = new_owner;
            last_d   = new_owner;
            dwell_d  = '0;
            switch_d = 1'b1;
        end
    end

    always_comb begin
        grant_oh = '0;
        if (state_q == HOLD) grant_oh[owner_q] = 1'b1;

        for (int unsigned i = 0; i < N_SRC; i++) begin
            rgb_arr[i] = bus.src_rgb[i*24 +: 24];
        end

        vs_prev_d = bus.vs_in;
        hs_d      = bus.hs_in;
        vs_d      = bus.vs_in;
        de_d      = bus.de_in;
        rgb_d     = (bus.de_in && state_q == HOLD) ? rgb_arr[owner_q] : BLACK_RGB;

        bus.hs_o         = hs_q;
        bus.vs_o         = vs_q;
        bus.de_o         = de_q;
        bus.rgb_o        = rgb_q;
        bus.grant        = grant_oh;
        bus.grant_valid  = (state_q == HOLD);
        bus.switch_pulse = switch_q;
    end

endmodule

// File: doc/video_src_scheduler.md
Name: video_src_scheduler

Overview:
- Frame-synchronous arbiter that shares one video output path (the colour-bar timing generator's hs/vs/de and pixel bus) between N pixel sources: colour bar, camera path, overlay, test image.
- Ownership changes only at a frame boundary, so a frame is never torn. Each owner keeps the path for a minimum number of frames. Owners are chosen round-robin, and a host force override is supported.
- Sits between the timing generator/sources and the HDMI/LCD output encoder.

Parameters:
- N_SRC, 4, number of requesting sources (2..8)
- IDX_W, 2, width of a source index, = clog2(N_SRC)
- MIN_FRAMES, 4, frames a granted source holds before it can be pre-empted by a round-robin switch (1..255)
- VS_POL, 1'b1, active level of vs_in

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-low
- hs_in  in  1  horizontal sync from timing generator
- vs_in  in  1  vertical sync from timing generator
- de_in  in  1  video valid from timing generator
- src_req  in  N_SRC  per-source request to own the output (level)
- src_rgb  in  N_SRC*24  per-source pixel {r,g,b}; source i occupies bits [24i+23:24i]
- force_en  in  1  host override enable (level)
- force_idx  in  IDX_W  source forced while force_en=1
- hs_o  out  1  hs_in delayed 1 clk
- vs_o  out  1  vs_in delayed 1 clk
- de_o  out  1  de_in delayed 1 clk
- rgb_o  out  24  selected pixel, registered
- grant  out  N_SRC  one-hot current owner; all zero when none
- grant_valid  out  1  an owner exists
- switch_pulse  out  1  one-clk pulse in the first cycle a new grant is in effect

Behaviour:
- Reset (rst=0 at posedge clk): hs_o/vs_o/de_o=0, rgb_o=0, grant=0, grant_valid=0, switch_pulse=0, dwell_cnt=0, state=IDLE. The round-robin pointer is set so the first search starts at index 0 (last=N_SRC-1). Reset mid-frame takes effect immediately; re-acquisition waits for the next frame_start.
- frame_start: vs_in==VS_POL in this cycle and !=VS_POL in the previous (registered vs_d, reset value !VS_POL). Grant changes only in the clock edge at which frame_start is true. The new grant is visible the following cycle, with switch_pulse=1 in that cycle.
- Arbitration pick (combinational rr_pick): first asserted src_req scanning from (last+1) mod N_SRC upward with wrap. The last owner is considered last.
- FSM states IDLE, HOLD:
  - IDLE: at frame_start
    - if force_en: grant force_idx, go HOLD
    - else if any src_req: grant rr_pick, go HOLD
    - else stay IDLE
  - HOLD: at frame_start, first matching rule wins:
    - (a) force_en and force_idx != owner: switch to force_idx.
    - (b) force_en and force_idx == owner: stay; dwell_cnt increments but no switch.
    - (c) owner's src_req=0: switch to rr_pick of the remaining requests, or go to IDLE (grant=0) if none.
    - (d) dwell_cnt >= MIN_FRAMES-1 and another src_req set: switch to rr_pick.
    - (e) otherwise stay, dwell_cnt+1 saturating at 255.
  - Any switch resets dwell_cnt=0 and updates last.
- Force is honoured even if src_req[force_idx]=0. A force_idx >= N_SRC is ignored and treated as force_en=0.
- Mid-frame src_req/force changes are ignored until the next frame_start.
- Datapath, latency 1 clk:
  - hs_o/vs_o/de_o = hs_in/vs_in/de_in registered.
  - rgb_o = src_rgb[owner] when de_in=1 and grant_valid=1; else 0.
  - The mux uses the registered grant.
- frame_start with de_in=1 cannot occur in legal timing; no special handling.

Decomposition:
- Package vsched_pkg:
  - state enum {IDLE, HOLD}
  - BLACK_RGB=24'h000000
  - dwell counter width = 8
  - the helper for IDX_W
- One sub-module, vsched_rr_pick: purely combinational round-robin priority search (req, last, excl_mask) -> {found, idx}. Instantiated once.

Test Plan:
1. MIN_FRAMES=4, only src_req[1] held for 6 frames:
   - grant=4'b0010 from the first frame_start, single switch_pulse.
   - rgb_o equals src_rgb[1] during every de_o=1 cycle, 1 clk after de_in.
2. src_req=4'b1111 from reset: owners sequence 0,1,2,3,0. Each switch occurs exactly 4 frame_starts after the previous one, and switch_pulse is high exactly once per switch.
3. Owner 2 drops src_req mid-frame, src_req[3]=1:
   - grant stays 4'b0100 until the next frame_start.
   - It then becomes 4'b1000 regardless of dwell_cnt=1.
4. force_en=1, force_idx=0 while owner 2 has dwell_cnt=1 and src_req[0]=0:
   - next frame_start gives grant=4'b0001.
   - Releasing force at dwell<MIN_FRAMES with src_req[0]=0 switches at the following frame_start.
5. All src_req dropped: the next frame_start gives grant=0, grant_valid=0, rgb_o=0 while de_o=1, and hs_o/vs_o keep toggling.
6. rst=0 asserted mid-line during HOLD:
   - all outputs 0 on the next clk.
   - After release with src_req=4'b0100, grant appears only after the next vs rising edge.
